// File: rtl/alu_muldiv.sv
`timescale 1ns/1ps
// alu_muldiv: registered RV32I ALU plus iterative RV32M multiply/divide.
// Optional macro RV_DIV_EN builds the divider; without it DIV/REM set err.
module alu_muldiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] data_rs1,
    input  logic [DATA_WIDTH-1:0] source_2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALU_result,
    output logic                  zero,
    output logic                  err
);

    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [SW-1:0] LAST = SW'(W - 1);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_XOR  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SRL  = 5'b01000;
    localparam logic [4:0] OP_SLL  = 5'b01001;
    localparam logic [4:0] OP_SRA  = 5'b01010;
    localparam logic [4:0] OP_SLT  = 5'b01100;
    localparam logic [4:0] OP_SLTU = 5'b01110;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [W-1:0]   r_b;
    logic [2*W-1:0] r_acc;
    logic [SW-1:0]  r_cnt;
    logic [1:0]     r_op;
    logic           r_neg;
    logic [W-1:0]   r_result;
    logic           r_zero;
    logic           r_err;

    logic           w_is_mul;
    logic           w_is_div;
    logic           w_a_sgn;
    logic           w_b_sgn;
    logic           w_a_neg;
    logic           w_b_neg;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W-1:0]   w_base;
    logic [W:0]     w_mul_sum;
    logic [2*W-1:0] w_mul_acc;
    logic [2*W-1:0] w_mul_fix;
    logic [W-1:0]   w_mul_res;
    logic           w_last;
    logic           w_load;
    logic [W-1:0]   w_res_d;
    logic           w_err_d;

    assign in_ready   = (r_state == IDLE);
    assign out_valid  = (r_state == DONE);
    assign ALU_result = r_result;
    assign zero       = r_zero;
    assign err        = r_err;

    assign w_is_mul = (op[4:2] == 3'b100);
    assign w_is_div = (op[4:2] == 3'b101);

    // MULHSU treats only A as signed; MULHU and the U divides neither.
    assign w_a_sgn = w_is_mul ? (op[1:0] != 2'b11) : !op[0];
    assign w_b_sgn = w_is_mul ? !op[1] : !op[0];
    assign w_a_neg = w_a_sgn & data_rs1[W-1];
    assign w_b_neg = w_b_sgn & source_2[W-1];
    assign w_a_mag = w_a_neg ? -data_rs1 : data_rs1;
    assign w_b_mag = w_b_neg ? -source_2 : source_2;

    assign w_last = (r_cnt == LAST);

    // Multiplier: A magnitude sits in the low half and is shifted out.
    assign w_mul_sum = {1'b0, r_acc[2*W-1:W]}
                     + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[W-1:1]};
    assign w_mul_fix = r_neg ? -w_mul_acc : w_mul_acc;
    assign w_mul_res = (r_op == 2'b00) ? w_mul_fix[W-1:0]
                                       : w_mul_fix[2*W-1:W];

`ifdef RV_DIV_EN
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic           r_rneg;
    logic           w_div_zero;
    logic           w_div_ovf;
    logic           w_div_sp;
    logic [W-1:0]   w_sp_res;
    logic [W:0]     w_div_sh;
    logic [W:0]     w_div_try;
    logic           w_div_ok;
    logic [W-1:0]   w_div_rem;
    logic [2*W-1:0] w_div_acc;
    logic [W-1:0]   w_div_q;
    logic [W-1:0]   w_div_r;
    logic [W-1:0]   w_div_res;

    assign w_div_zero = (source_2 == '0);
    assign w_div_ovf  = !op[0] && (data_rs1 == MIN_NEG) && (&source_2);
    assign w_div_sp   = w_div_zero | w_div_ovf;
    assign w_sp_res   = !op[1] ? (w_div_zero ? '1 : data_rs1)
                               : (w_div_zero ? data_rs1 : '0);

    // Restoring step: high half is the partial remainder, low half
    // shifts the dividend out while quotient bits shift in.
    assign w_div_sh  = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_div_try = w_div_sh - {1'b0, r_b};
    assign w_div_ok  = !w_div_try[W];
    assign w_div_rem = w_div_ok ? w_div_try[W-1:0] : w_div_sh[W-1:0];
    assign w_div_acc = {w_div_rem, r_acc[W-2:0], w_div_ok};
    assign w_div_q   = r_neg ? -w_div_acc[W-1:0] : w_div_acc[W-1:0];
    assign w_div_r   = r_rneg ? -w_div_acc[2*W-1:W]
                              : w_div_acc[2*W-1:W];
    assign w_div_res = r_op[1] ? w_div_r : w_div_q;
`endif

    // Single-cycle base ALU; unlisted codes fall back to add.
    always_comb begin
        w_base = data_rs1 + source_2;
        case (op)
            OP_AND:  w_base = data_rs1 & source_2;
            OP_OR:   w_base = data_rs1 | source_2;
            OP_ADD:  w_base = data_rs1 + source_2;
            OP_XOR:  w_base = data_rs1 ^ source_2;
            OP_SUB:  w_base = data_rs1 - source_2;
            OP_SRL:  w_base = data_rs1 >> source_2[SW-1:0];
            OP_SLL:  w_base = data_rs1 << source_2[SW-1:0];
            OP_SRA:  w_base = $signed(data_rs1) >>> source_2[SW-1:0];
            OP_SLT:  w_base = {{(W-1){1'b0}},
                               $signed(data_rs1) < $signed(source_2)};
            OP_SLTU: w_base = {{(W-1){1'b0}}, data_rs1 < source_2};
            default: w_base = data_rs1 + source_2;
        endcase
    end

    // Next-state logic for the request/iterate/present cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    if (w_is_mul) begin
                        w_next = MUL;
`ifdef RV_DIV_EN
                    end else if (w_is_div && !w_div_sp) begin
                        w_next = DIV;
`endif
                    end else begin
                        w_next = DONE;
                    end
                end
            end
            MUL:     if (w_last) w_next = DONE;
            DIV:     if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Selects which value, if any, is captured as the result this cycle.
    always_comb begin
        w_load  = 1'b0;
        w_res_d = '0;
        w_err_d = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (in_valid && !w_is_mul) begin
                    if (w_is_div) begin
`ifdef RV_DIV_EN
                        w_load  = w_div_sp;
                        w_res_d = w_sp_res;
`else
                        w_load  = 1'b1;
                        w_err_d = 1'b1;
`endif
                    end else begin
                        w_load  = 1'b1;
                        w_res_d = w_base;
                    end
                end
            end
            MUL: begin
                w_load  = w_last;
                w_res_d = w_mul_res;
            end
`ifdef RV_DIV_EN
            DIV: begin
                w_load  = w_last;
                w_res_d = w_div_res;
            end
`endif
            default: w_load = 1'b0;
        endcase
    end

    // State register; reset aborts any op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Operand capture and one iteration step per busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_op  <= '0;
            r_neg <= 1'b0;
`ifdef RV_DIV_EN
            r_rneg <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_b   <= w_b_mag;
                        r_acc <= {{W{1'b0}}, w_a_mag};
                        r_cnt <= '0;
                        r_op  <= op[1:0];
                        r_neg <= w_a_neg ^ w_b_neg;
`ifdef RV_DIV_EN
                        r_rneg <= w_a_neg;
`endif
                    end
                end
                MUL: begin
                    r_acc <= w_mul_acc;
                    r_cnt <= r_cnt + SW'(1);
                end
`ifdef RV_DIV_EN
                DIV: begin
                    r_acc <= w_div_acc;
                    r_cnt <= r_cnt + SW'(1);
                end
`endif
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Result, zero and err always update together on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load) begin
            r_result <= w_res_d;
            r_zero   <= (w_res_d == '0);
            r_err    <= w_err_d;
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
`timescale 1ns/1ps
// tb_alu_muldiv: random and directed stimulus against an arithmetic model.
module tb_alu_muldiv;

    localparam logic [4:0] AND_  = 5'b00000;
    localparam logic [4:0] ADD   = 5'b00010;
    localparam logic [4:0] SUB   = 5'b00110;
    localparam logic [4:0] SRA   = 5'b01010;
    localparam logic [4:0] MUL   = 5'b10000;
    localparam logic [4:0] MULH  = 5'b10001;
    localparam logic [4:0] MULSU = 5'b10010;
    localparam logic [4:0] MULHU = 5'b10011;
    localparam logic [4:0] DIV   = 5'b10100;
    localparam logic [4:0] DIVU  = 5'b10101;
    localparam logic [4:0] REM   = 5'b10110;

    logic        clk = 0;
    logic        rst = 1;
    logic        in_valid = 0;
    logic        in_ready;
    logic [4:0]  op = 0;
    logic [31:0] a = 0;
    logic [31:0] b = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] res;
    logic        zero;
    logic        err;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int e_lat = 1;
    int got_lat = 0;
    bit pend = 0;
    bit seen = 0;
    logic [31:0] e_res = 0;
    logic        e_err = 0;

    alu_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .op(op),
        .data_rs1(a),
        .source_2(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ALU_result(res),
        .zero(zero),
        .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Reference behaviour straight from the RISC-V definitions.
    function automatic logic [32:0] model(input logic [4:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint ux = {32'b0, x};
        longint uy = {32'b0, y};
        logic [63:0] p;
        logic [31:0] r;
        logic e;
        bit dz = (y == 0);
        bit ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        e = 0;
        case (o)
            5'b00000: r = x & y;
            5'b00001: r = x | y;
            5'b00011: r = x ^ y;
            5'b00110: r = x - y;
            5'b01000: r = x >> y[4:0];
            5'b01001: r = x << y[4:0];
            5'b01010: r = $signed(x) >>> y[4:0];
            5'b01100: r = ($signed(x) < $signed(y)) ? 1 : 0;
            5'b01110: r = (x < y) ? 1 : 0;
            5'b10000: begin p = sx * sy; r = p[31:0]; end
            5'b10001: begin p = sx * sy; r = p[63:32]; end
            5'b10010: begin p = sx * uy; r = p[63:32]; end
            5'b10011: begin p = ux * uy; r = p[63:32]; end
`ifdef RV_DIV_EN
            5'b10100: begin
                p = dz ? 64'd0 : (ov ? 64'd0 : sx / sy);
                r = dz ? 32'hFFFF_FFFF : (ov ? x : p[31:0]);
            end
            5'b10101: r = dz ? 32'hFFFF_FFFF : x / y;
            5'b10110: begin
                p = (dz || ov) ? 64'd0 : sx % sy;
                r = dz ? x : (ov ? 32'd0 : p[31:0]);
            end
            5'b10111: r = dz ? x : x % y;
`else
            5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                r = 0;
                e = 1;
            end
`endif
            default: r = x + y;
        endcase
        return {e, r};
    endfunction

    function automatic int lat(input logic [4:0] o,
                               input logic [31:0] x,
                               input logic [31:0] y);
        if (o[4:2] == 3'b100) return 33;
`ifdef RV_DIV_EN
        if (o[4:2] == 3'b101) begin
            if (y == 0) return 1;
            if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                return 1;
            return 33;
        end
`endif
        return 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Every cycle: idle checks, busy checks, or result vs model.
    always @(negedge clk) begin
        int l;
        if (!rst) begin
            l = cyc - acc_cyc + 1;
            if (!pend) begin
                chk("idle_in_ready", in_ready, 1);
                chk("idle_out_valid", out_valid, 0);
            end else if (!out_valid) begin
                chk("busy_in_ready", in_ready, 0);
                if (l >= e_lat) chk("late_out_valid", l, e_lat - 1);
            end else begin
                if (!seen) begin
                    got_lat = l;
                    chk("latency", l, e_lat);
                    seen = 1;
                end
                chk("done_in_ready", in_ready, 0);
                chk("result", res, e_res);
                chk("zero", zero, e_res == 0);
                chk("err", err, e_err);
            end
        end
    end

    task automatic issue(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        logic [32:0] m;
        @(negedge clk);
        chk("issue_ready", in_ready, 1);
        op = o;
        a = x;
        b = y;
        in_valid = 1;
        m = model(o, x, y);
        e_err = m[32];
        e_res = m[31:0];
        e_lat = lat(o, x, y);
        @(posedge clk);
        #1;
        in_valid = 0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
        acc_cyc = cyc;
        seen = 0;
        pend = 1;
    endtask

    task automatic finish(input int hold, output logic [31:0] r,
                          output logic e);
        int n;
        out_ready = (hold == 0);
        @(negedge clk);
        n = 1;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("timeout", 0, 1);
            r = 'x;
            e = 'x;
            rst = 1;
            pend = 0;
            @(negedge clk);
            rst = 0;
            out_ready = 0;
            return;
        end
        r = res;
        e = err;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1;
            op = ADD;
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        pend = 0;
    endtask

    task automatic run(input logic [4:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int hold,
                       output logic [31:0] r, output logic e);
        issue(o, x, y);
        finish(hold, r, e);
    endtask

    initial begin
        logic [31:0] r;
        logic e;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", res, 0);
        chk("rst_zero", zero, 0);
        chk("rst_err", err, 0);
        rst = 0;

        run(ADD, 5, 7, 0, r, e);
        chk("add_5_7", r, 12);
        chk("add_lat", got_lat, 1);
        run(SUB, 9, 9, 0, r, e);
        chk("sub_9_9", r, 0);
        chk("sub_zero", zero, 1);
        run(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, r, e);
        chk("mulhu_ff", r, 32'hFFFF_FFFE);
        chk("mulhu_lat", got_lat, 33);
        run(MUL, -32'sd2, 3, 0, r, e);
        chk("mul_m2_3", r, 32'hFFFF_FFFA);
        run(MULH, -32'sd2, 3, 0, r, e);
        chk("mulh_m2_3", r, 32'hFFFF_FFFF);
        run(MULSU, 32'hFFFF_FFFF, 2, 0, r, e);
        chk("mulhsu_m1_2", r, 32'hFFFF_FFFF);
`ifdef RV_DIV_EN
        run(DIV, -32'sd7, 2, 0, r, e);
        chk("div_m7_2", r, 32'hFFFF_FFFD);
        chk("div_lat", got_lat, 33);
        run(REM, -32'sd7, 2, 0, r, e);
        chk("rem_m7_2", r, 32'hFFFF_FFFF);
        chk("rem_lat", got_lat, 33);
        run(DIVU, 5, 0, 0, r, e);
        chk("divu_by0", r, 32'hFFFF_FFFF);
        chk("divu_by0_lat", got_lat, 1);
        run(REM, 5, 0, 0, r, e);
        chk("rem_by0", r, 5);
        run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, e);
        chk("div_ovf", r, 32'h8000_0000);
        chk("div_ovf_lat", got_lat, 1);
        run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, r, e);
        chk("rem_ovf", r, 0);
`else
        run(DIVU, 10, 3, 0, r, e);
        chk("nodiv_res", r, 0);
        chk("nodiv_err", e, 1);
        chk("nodiv_lat", got_lat, 1);
`endif
        run(SRA, 32'h8000_0000, 4, 0, r, e);
        chk("sra_res", r, 32'hF800_0000);
        chk("sra_err", e, 0);

        run(MUL, 7, 9, 5, r, e);
        chk("hold_mul", r, 63);
        run(AND_, 32'hF0F0, 32'h0FF0, 5, r, e);
        chk("hold_and", r, 32'h00F0);

        issue(MUL, 123, 456);
        repeat (9) @(negedge clk);
        #2;
        rst = 1;
        pend = 0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", res, 0);
        chk("abort_zero", zero, 0);
        chk("abort_err", err, 0);
        chk("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 0;
        run(ADD, 1, 1, 0, r, e);
        chk("after_rst_add", r, 2);

        for (int i = 0; i < 300; i++) begin
            run(5'($urandom_range(0, 31)), pick(), pick(),
                $urandom_range(0, 3), r, e);
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised, sequential successor to the processor's single-cycle ALU. It executes the RV32I integer ops in one registered cycle, plus the RV32M multiply/divide ops iteratively over DATA_WIDTH cycles. A valid/ready handshake lets the datapath stall while a long op is in flight. It sits in the execute stage between the register-file/immediate mux and the writeback mux.

## Interface
- DATA_WIDTH, 32: operand/result width; must be a power of two, ≥8.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  5  operation code (see Operation).
- data_rs1  in  DATA_WIDTH  operand A.
- source_2  in  DATA_WIDTH  operand B (register or immediate).
- out_valid  out  1  ALU_result/zero/err valid.
- out_ready  in  1  consumer accepts result.
- ALU_result  out  DATA_WIDTH  registered result.
- zero  out  1  ALU_result == 0, registered with the result.
- err  out  1  unsupported op (see Configuration).

## Operation
- Op codes, base (op[4]=0): 00010 add, 00110 sub, 00000 and, 00001 or, 00011 xor, 01000 srl, 01001 sll, 01010 sra, 01100 slt, 01110 sltu. Any other op[4]=0 code performs add.
- Op codes, M (op[4]=1): 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU. Codes 11xxx perform add.
- Shift amount is source_2[$clog2(DATA_WIDTH)-1:0]; upper bits are ignored.
- slt/sltu return 1 or 0, zero-extended.
- FSM states are IDLE, MUL, DIV, DONE.
  - IDLE: in_ready=1. An accept (in_valid & in_ready) latches operands and op.
    - Base op: result computed and registered this cycle; go to DONE.
    - MUL*: go to MUL.
    - DIV/REM with divisor 0 or signed overflow: go to DONE directly.
    - Other DIV/REM: go to DIV.
  - MUL: unsigned shift-add on operand magnitudes into a 2·DATA_WIDTH accumulator, one bit per cycle. Counter runs 0..DATA_WIDTH-1, then a sign fixup (negate the product if the operand signs differ for the signed variants). MUL returns the low half; MULH/MULHSU/MULHU return the high half. Go to DONE.
  - DIV: restoring division on magnitudes, one quotient bit per cycle, DATA_WIDTH iterations. Quotient sign = sign(A) xor sign(B); remainder sign = sign(A). Go to DONE.
  - DONE: out_valid=1 and outputs held stable. On out_ready, go to IDLE.
- Divide special cases (RISC-V semantics):
  - Divide by zero: quotient all-ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder 0.
- in_ready=0 in MUL, DIV and DONE. in_valid is ignored there; no queuing.
- An op change while busy has no effect.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, ALU_result=0, zero=0, err=0, counter 0.
- Latency counts from the accept edge to the first cycle with out_valid high:
  - Base ops and divide special cases: 1 cycle.
  - MUL* and regular DIV/REM: DATA_WIDTH+1 cycles.
- Throughput: at most one op per 2 cycles, because the IDLE→DONE→IDLE round trip is mandatory.
- With out_ready held high in DONE, out_valid is a 1-cycle pulse.
- Backpressure holds DONE for any duration with all outputs unchanged.
- rst mid-operation aborts immediately: all outputs return to reset values, and a partial result is never presented.
- zero and err change only on the same edge as ALU_result.

## Configuration
- RV_DIV_EN defined: the divider datapath and DIV state are compiled in, and DIV/DIVU/REM/REMU behave as above.
- RV_DIV_EN undefined: no divider logic is built. Codes 101xx complete in 1 cycle with ALU_result=0, zero=1, err=1.
- err is always 0 for supported ops. MUL* ops are unaffected by the macro.

## Test plan
- add 5+7 -> ALU_result=12, zero=0, out_valid 1 cycle after accept. sub 9-9 -> result 0, zero=1.
- MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE, with out_valid exactly 33 cycles after accept. MUL -2×3 -> 0xFFFFFFFA; MULH -2×3 -> 0xFFFFFFFF; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each at 33 cycles. DIVU 5/0 -> 0xFFFFFFFF at 1 cycle. REM 5/0 -> 5. DIV 0x80000000/-1 -> 0x80000000 at 1 cycle; REM -> 0.
- Hold out_ready low 5 cycles in DONE -> ALU_result stable and in_ready=0 throughout; pulse in_valid meanwhile -> request ignored.
- Assert rst on cycle 10 of a MUL -> out_valid=0, ALU_result=0, in_ready=1 immediately. After release, add 1+1 -> 2.
- Build without RV_DIV_EN, issue DIVU 10/3 -> 1-cycle latency, ALU_result=0, err=1. A following sra 0x80000000>>>4 -> 0xF8000000, err=0.
